// File: rtl/arb_pkg.sv
// Shared types and helpers for the register arbiter slice.
// RR_ARB_EN selects round-robin arbitration; fixed priority otherwise.
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational winner search over level requests.
// RR_ARB_EN: rotate search from ptr; otherwise lowest set index wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
`ifdef RR_ARB_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [IW-1:0] win,
  output logic          any_req
);

`ifdef RR_ARB_EN
  int idx;
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // explicit wrap so non-power-of-two N never indexes past N-1
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = IW'(idx);
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    any_req = |req;
    for (int k = N - 1; k >= 0; k--)
      if (req[k]) win = IW'(k);
  end
`endif

endmodule

// File: rtl/rr_reg_arbiter.sv
// Shared W-bit register written by one of N requesters per grant.
// RR_ARB_EN enables round-robin; default build is fixed priority.
module rr_reg_arbiter
  import arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic            CLK,
  input  logic            CLRN,
  input  logic [N-1:0]    REQ,
  input  logic [N*W-1:0]  DATA_IN,
  output logic [N-1:0]    GNT,
  output logic [W-1:0]    Q,
  output logic [IW-1:0]   OWNER,
  output logic            BUSY
);

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        sel, win;
  logic                 any_req, en;
  logic [N-1:0][W-1:0]  data_arr;
  logic [W-1:0]         d;

  assign data_arr = DATA_IN;
  assign d        = data_arr[sel];

`ifdef RR_ARB_EN
  logic [IW-1:0] ptr;
  rr_pick #(.N(N)) u_pick (.req(REQ), .ptr(ptr), .win(win), .any_req(any_req));
`else
  rr_pick #(.N(N)) u_pick (.req(REQ), .win(win), .any_req(any_req));
`endif

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = WRITE;
      WRITE: begin
        en        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      state <= IDLE;
      sel   <= '0;
      Q     <= '0;
      OWNER <= '0;
`ifdef RR_ARB_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      // sel frozen for the whole WRITE cycle
      if (state == IDLE && any_req) sel <= win;
      if (en) begin
        Q     <= d;
        OWNER <= sel;
`ifdef RR_ARB_EN
        ptr   <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
`endif
      end
    end
  end

  // outputs decode registered state only
  assign BUSY = (state == WRITE);
  assign GNT  = BUSY ? (N'(1) << sel) : '0;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter (N=4, W=8) with an expected-grant scoreboard.
// Expectations follow RR_ARB_EN when defined, fixed priority otherwise.
module tb_rr_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         CLRN;
  logic [N-1:0] REQ;
  logic [N*W-1:0] DATA_IN;
  logic [N-1:0] GNT;
  logic [W-1:0] Q;
  logic [1:0]   OWNER;
  logic         BUSY;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic [1:0]   owner;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;

  rr_reg_arbiter #(.N(N), .W(W)) dut (
    .CLK(CLK), .CLRN(CLRN), .REQ(REQ), .DATA_IN(DATA_IN),
    .GNT(GNT), .Q(Q), .OWNER(OWNER), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
`ifdef RR_ARB_EN
      idx = (p + k) % N;
`else
      idx = k;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive a request, predict the winner, then check the WRITE cycle and the result.
  task automatic write_one(input string tag, input logic [N-1:0] req, input logic [N*W-1:0] data);
    exp_t e;
    int   w;
    logic [N*W-1:0] dv;
    REQ     = req;
    DATA_IN = data;
    dv      = data;
    w       = pick(req, m_ptr);
    e.gnt   = N'(1) << w;
    e.q     = dv[w*W +: W];
    e.owner = 2'(w);
    exp_q.push_back(e);
    m_ptr   = (w + 1) % N;
    tick();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_gnt"},  32'(GNT),  32'(e.gnt));
      chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      tick();
      chk({tag, "_q"},     32'(Q),     32'(e.q));
      chk({tag, "_owner"}, 32'(OWNER), 32'(e.owner));
      chk({tag, "_gnt0"},  32'(GNT),   32'd0);
      chk({tag, "_busy0"}, 32'(BUSY),  32'd0);
    end
  endtask

  task automatic do_reset();
    CLRN = 1'b0;
    tick();
    tick();
    CLRN  = 1'b1;
    m_ptr = 0;
  endtask

  initial begin
    CLRN    = 1'b0;
    REQ     = 4'b1111;
    DATA_IN = 32'hDEAD_BEEF;

    // 1: reset with requests pending
    tick();
    tick();
    chk("rst_gnt",   32'(GNT),   32'd0);
    chk("rst_busy",  32'(BUSY),  32'd0);
    chk("rst_q",     32'(Q),     32'd0);
    chk("rst_owner", 32'(OWNER), 32'd0);
    CLRN = 1'b1;

    // 2: single requester 2
    write_one("t2", 4'b0100, 32'h00A5_0000);
    REQ = '0;

    // 3: all requesting, distinct data, starting from ptr 0
    do_reset();
    for (int i = 0; i < 5; i++)
      write_one($sformatf("t3_%0d", i), 4'b1111, 32'h4433_2211);

    // 4: grant to 1 leaves ptr at 2, then 1010 resolves 3 before 1
    write_one("t4a", 4'b0010, 32'h4433_2211);
    write_one("t4b", 4'b1010, 32'h4433_2211);
    write_one("t4c", 4'b1010, 32'h4433_2211);
    REQ = '0;

    // 5: reset landing on the WRITE cycle suppresses the write
    tick();
    REQ     = 4'b0001;
    DATA_IN = 32'h0000_003C;
    tick();
    chk("t5_gnt", 32'(GNT), 32'h1);
    REQ  = '0;
    CLRN = 1'b0;
    tick();
    CLRN  = 1'b1;
    m_ptr = 0;
    chk("t5_q",     32'(Q),     32'd0);
    chk("t5_gnt0",  32'(GNT),   32'd0);
    chk("t5_busy",  32'(BUSY),  32'd0);
    chk("t5_owner", 32'(OWNER), 32'd0);

    // 6: idle hold after a write of 5A
    write_one("t6w", 4'b0100, 32'h005A_0000);
    REQ = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t6_q_%0d", i),    32'(Q),    32'h5A);
      chk($sformatf("t6_gnt_%0d", i),  32'(GNT),  32'd0);
      chk($sformatf("t6_busy_%0d", i), 32'(BUSY), 32'd0);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
